// File: rtl/vga_pkg.sv
// Shared VGA raster definitions: default 640x480@60 timing, coordinate width, helpers.
package vga_pkg;

  localparam int unsigned COORD_W = 10;

  localparam int unsigned VGA_CLK_DIV     = 2;
  localparam int unsigned VGA_ANIM_FRAMES = 30;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef logic [COORD_W-1:0] coord_t;

  // Register width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned bits_for(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap strobe, active-low sync and active-region flag.
// sync_n and in_active are registered from the next count so they line up with count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned FP     = VGA_H_FP,
  parameter int unsigned SYNC   = VGA_H_SYNC,
  parameter int unsigned BP     = VGA_H_BP
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step,
  output logic [COORD_W-1:0] count,
  output logic               wrap,
  output logic               sync_n,
  output logic               in_active
);

  localparam int unsigned TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam int unsigned SYNC_START = ACTIVE + FP;
  localparam int unsigned SYNC_END   = SYNC_START + SYNC;
  localparam int unsigned EXT_W      = COORD_W + 1;

  logic               at_end;
  logic [COORD_W-1:0] count_nxt;
  logic [EXT_W-1:0]   count_nxt_ext;

  // Next position and wrap detection; wrap only fires on an actual step.
  always_comb begin
    at_end        = (count == COORD_W'(TOTAL - 1));
    count_nxt     = at_end ? '0 : count + COORD_W'(1);
    count_nxt_ext = {1'b0, count_nxt};
    wrap          = step & at_end;
  end

  // Position and decoded flags advance together on step, hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      sync_n    <= 1'b1;
      in_active <= (ACTIVE > 0);
    end else if (step) begin
      count     <= count_nxt;
      sync_n    <= ~((count_nxt_ext >= EXT_W'(SYNC_START)) && (count_nxt_ext < EXT_W'(SYNC_END)));
      in_active <= (count_nxt_ext < EXT_W'(ACTIVE));
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel clock-enable, h/v counters, syncs, active flag,
// per-frame pulse and the sprite animation phase troca.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV     = VGA_CLK_DIV,
  parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
  parameter int unsigned H_FP        = VGA_H_FP,
  parameter int unsigned H_SYNC      = VGA_H_SYNC,
  parameter int unsigned H_BP        = VGA_H_BP,
  parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
  parameter int unsigned V_FP        = VGA_V_FP,
  parameter int unsigned V_SYNC      = VGA_V_SYNC,
  parameter int unsigned V_BP        = VGA_V_BP,
  parameter int unsigned ANIM_FRAMES = VGA_ANIM_FRAMES
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pix_en,
  output logic [COORD_W-1:0] h_counter,
  output logic [COORD_W-1:0] v_counter,
  output logic               h_sync,
  output logic               v_sync,
  output logic               active,
  output logic               frame_start,
  output logic               troca
);

  localparam int unsigned DIV_W = bits_for(CLK_DIV);
  localparam int unsigned FC_W  = $clog2(ANIM_FRAMES + 1);

  logic [DIV_W-1:0] div_cnt;
  logic [FC_W-1:0]  frame_cnt;
  logic             started;
  logic             h_wrap;
  logic             v_wrap;
  logic             h_in_active;
  logic             v_in_active;
  logic             frame_wrap;

  // Pixel clock-enable: one-clk strobe every CLK_DIV clks, first one CLK_DIV clks after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      pix_en  <= 1'b0;
    end else if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
      div_cnt <= '0;
      pix_en  <= 1'b1;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      pix_en  <= 1'b0;
    end
  end

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk       (clk),
    .reset     (reset),
    .step      (pix_en),
    .count     (h_counter),
    .wrap      (h_wrap),
    .sync_n    (h_sync),
    .in_active (h_in_active)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk       (clk),
    .reset     (reset),
    .step      (h_wrap),
    .count     (v_counter),
    .wrap      (v_wrap),
    .sync_n    (v_sync),
    .in_active (v_in_active)
  );

  assign frame_wrap = h_wrap & v_wrap;

  // Frame pulse, first-pixel tracking and animation phase counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_start <= 1'b0;
      started     <= 1'b0;
      frame_cnt   <= '0;
      troca       <= 1'b0;
    end else begin
      frame_start <= frame_wrap;
      if (pix_en) begin
        started <= 1'b1;
      end
      if (frame_wrap) begin
        if (frame_cnt == FC_W'(ANIM_FRAMES - 1)) begin
          frame_cnt <= '0;
          troca     <= ~troca;
        end else begin
          frame_cnt <= frame_cnt + FC_W'(1);
        end
      end
    end
  end

  // The reset-state pixel (0,0) stays inactive until the raster has moved once.
  assign active = started & h_in_active & v_in_active;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: three parameterisations, random resets,
// per-clk scoreboard against an arithmetic raster model plus explicit timing checks.
module tb_vga_timing_gen;

  typedef struct packed {
    logic       pe;
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       act;
    logic       fs;
    logic       tr;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;

  logic       pe_a, hs_a, vs_a, act_a, fs_a, tr_a;
  logic [9:0] h_a, v_a;
  logic       pe_b, hs_b, vs_b, act_b, fs_b, tr_b;
  logic [9:0] h_b, v_b;
  logic       pe_c, hs_c, vs_c, act_c, fs_c, tr_c;
  logic [9:0] h_c, v_c;

  vga_timing_gen u_a (
    .clk(clk), .reset(rst_a), .pix_en(pe_a), .h_counter(h_a), .v_counter(v_a),
    .h_sync(hs_a), .v_sync(vs_a), .active(act_a), .frame_start(fs_a), .troca(tr_a)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .ANIM_FRAMES(2)
  ) u_b (
    .clk(clk), .reset(rst_b), .pix_en(pe_b), .h_counter(h_b), .v_counter(v_b),
    .h_sync(hs_b), .v_sync(vs_b), .active(act_b), .frame_start(fs_b), .troca(tr_b)
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(10), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .ANIM_FRAMES(3)
  ) u_c (
    .clk(clk), .reset(rst_c), .pix_en(pe_c), .h_counter(h_c), .v_counter(v_c),
    .h_sync(hs_c), .v_sync(vs_c), .active(act_c), .frame_start(fs_c), .troca(tr_c)
  );

  int checks = 0;
  int errors = 0;

  // Expected outputs n clk edges after reset release, from the raster rules directly.
  function automatic obs_t model(input int n, input int d,
                                 input int ha, input int hf, input int hsw, input int hb,
                                 input int va, input int vf, input int vsw, input int vb,
                                 input int af);
    int ht, vt, k, h, v, f;
    obs_t o;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    k  = (n == 0) ? 0 : (n - 1) / d;
    h  = k % ht;
    v  = (k / ht) % vt;
    f  = k / (ht * vt);
    o.pe  = (n >= 1) && (n % d == 0);
    o.h   = 10'(h);
    o.v   = 10'(v);
    o.hs  = !((h >= ha + hf) && (h < ha + hf + hsw));
    o.vs  = !((v >= va + vf) && (v < va + vf + vsw));
    o.act = (k > 0) && (h < ha) && (v < va);
    o.fs  = (n >= 2) && ((n - 1) % d == 0) && (k % (ht * vt) == 0);
    o.tr  = ((f / af) % 2) == 1;
    return o;
  endfunction

  function automatic obs_t exp_a(input int n);
    return model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33, 30);
  endfunction
  function automatic obs_t exp_b(input int n);
    return model(n, 1, 8, 2, 4, 2, 4, 1, 1, 1, 2);
  endfunction
  function automatic obs_t exp_c(input int n);
    return model(n, 3, 10, 3, 5, 4, 6, 2, 2, 3, 3);
  endfunction

  task automatic cmp(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got pe=%b h=%0d v=%0d hs=%b vs=%b act=%b fs=%b tr=%b required pe=%b h=%0d v=%0d hs=%b vs=%b act=%b fs=%b tr=%b",
               name, $time, got.pe, got.h, got.v, got.hs, got.vs, got.act, got.fs, got.tr,
               exp.pe, exp.h, exp.v, exp.hs, exp.vs, exp.act, exp.fs, exp.tr);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d required %0d", name, $time, got, exp);
    end
  endtask

  // Reference model: edge counts since release, expectations queued once per clk.
  int   n_a = 0, n_b = 0, n_c = 0;
  obs_t q_a[$];
  obs_t q_b[$];
  obs_t q_c[$];

  always @(posedge clk) begin
    n_a <= rst_a ? 0 : n_a + 1;
    n_b <= rst_b ? 0 : n_b + 1;
    n_c <= rst_c ? 0 : n_c + 1;
  end

  always @(negedge clk) begin
    q_a.push_back(exp_a(rst_a ? 0 : n_a));
    q_b.push_back(exp_b(rst_b ? 0 : n_b));
    q_c.push_back(exp_c(rst_c ? 0 : n_c));
  end

  // Handshake from stimulus to monitor for the immediate-reset snapshot.
  obs_t imm_obs_b;
  int   imm_seq_b = 0;
  logic timeout_b = 1'b0;
  logic done      = 1'b0;

  // Stimulus A: single reset, then free-running default timing.
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b0;
  end

  // Stimulus B: random resets, then a reset mid-frame while troca is set.
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b0;
    repeat (4) begin
      repeat ($urandom_range(150, 600)) @(posedge clk);
      #1 rst_b = 1'b1;
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1 rst_b = 1'b0;
    end
    begin : search
      logic found;
      found = 1'b0;
      for (int i = 0; i < 600; i++) begin
        @(posedge clk);
        #1;
        if (h_b == 10'd3 && v_b == 10'd2 && tr_b == 1'b1) begin
          found = 1'b1;
          break;
        end
      end
      if (found) begin
        #2 rst_b = 1'b1;
        #1 imm_obs_b = {pe_b, h_b, v_b, hs_b, vs_b, act_b, fs_b, tr_b};
        imm_seq_b++;
        @(posedge clk);
        #1 rst_b = 1'b0;
      end else begin
        timeout_b = 1'b1;
      end
    end
  end

  // Stimulus C: long runs between random resets so troca toggles are exercised.
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_c = 1'b0;
    repeat (2) begin
      repeat ($urandom_range(3000, 3800)) @(posedge clk);
      #1 rst_c = 1'b1;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1 rst_c = 1'b0;
    end
  end

  // Monitor: pops expectations and compares, plus line/frame interval checks.
  int   imm_seen_b = 0;
  logic prev_hs_a = 1'b1;
  logic have_fall_a = 1'b0;
  int   pe_since_fall_a = 0;
  int   low_pe_a = 0;
  logic have_fs_b = 1'b0;
  int   clk_since_fs_b = 0;
  int   fs_num_b = 0;
  int   intervals_b = 0;
  int   lines_a = 0;
  logic final_done = 1'b0;

  always @(negedge clk) begin
    obs_t e;
    #1;
    if (q_a.size() == 0) check_int("queue_a_empty", 0, 1);
    else begin e = q_a.pop_front(); cmp("dut_a", {pe_a, h_a, v_a, hs_a, vs_a, act_a, fs_a, tr_a}, e); end
    if (q_b.size() == 0) check_int("queue_b_empty", 0, 1);
    else begin e = q_b.pop_front(); cmp("dut_b", {pe_b, h_b, v_b, hs_b, vs_b, act_b, fs_b, tr_b}, e); end
    if (q_c.size() == 0) check_int("queue_c_empty", 0, 1);
    else begin e = q_c.pop_front(); cmp("dut_c", {pe_c, h_c, v_c, hs_c, vs_c, act_c, fs_c, tr_c}, e); end

    if (imm_seq_b != imm_seen_b) begin
      cmp("imm_reset_b", imm_obs_b, exp_b(0));
      imm_seen_b = imm_seq_b;
    end

    if (rst_a) begin
      have_fall_a = 1'b0;
      pe_since_fall_a = 0;
      low_pe_a = 0;
      prev_hs_a = 1'b1;
    end else begin
      if (prev_hs_a && !hs_a) begin
        if (have_fall_a) begin
          check_int("line_pix_en", pe_since_fall_a, 800);
          lines_a++;
        end
        have_fall_a = 1'b1;
        pe_since_fall_a = 0;
      end
      if (!prev_hs_a && hs_a) begin
        check_int("hsync_width", low_pe_a, 96);
        low_pe_a = 0;
      end
      if (pe_a) begin
        pe_since_fall_a++;
        if (!hs_a) low_pe_a++;
      end
      prev_hs_a = hs_a;
    end

    if (rst_b) begin
      have_fs_b = 1'b0;
      clk_since_fs_b = 0;
      fs_num_b = 0;
    end else begin
      clk_since_fs_b++;
      if (fs_b) begin
        if (have_fs_b) begin
          check_int("frame_interval_b", clk_since_fs_b, 112);
          intervals_b++;
        end
        fs_num_b++;
        check_int("troca_at_frame_b", int'(tr_b), (fs_num_b / 2) % 2);
        have_fs_b = 1'b1;
        clk_since_fs_b = 0;
      end
    end

    if (done && !final_done) begin
      final_done = 1'b1;
      check_int("reset_search_b", int'(timeout_b), 0);
      check_int("imm_reset_seen_b", imm_seen_b, 1);
      check_int("frame_intervals_seen_b", int'(intervals_b > 0), 1);
      check_int("lines_seen_a", int'(lines_a > 0), 1);
    end
  end

  initial begin
    repeat (11000) @(posedge clk);
    done = 1'b1;
    @(negedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
